argmax_classifier: RTL

Output stage placed directly downstream of the final neuron layer. It collects the activated score and the one-cycle output_ready pulse from each of NUM_CLASSES neurons. Once every score is captured, it scans them sequentially, one compare per cycle, to find the largest. It then presents the winning class index and score with a one-cycle result_valid pulse.

---
 rtl/argmax_classifier.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/argmax_classifier.sv
// argmax_classifier
// -----------------------------------------------------------------------------
// Output stage for the last neuron layer. Each neuron k delivers its score
// with a one-cycle score_ready[k] pulse. Once every class has delivered a
// score, the captured values are scanned one compare per clock. The winning
// index and score are then presented together with a one-cycle result_valid.
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   asynchronous, active-high reset
//   score_ready  in   [NUM_CLASSES]   per-class capture strobes
//   scores       in   [NUM_CLASSES] x signed DATA_WIDTH, valid with its strobe
//   class_index  out  index of the maximum from the last completed scan
//   max_score    out  value of that maximum
//   result_valid out  one-cycle pulse when class_index/max_score update
//   busy         out  high while scanning and during the result cycle
//   overrun      out  sticky: a strobe arrived while not collecting
// -----------------------------------------------------------------------------
module argmax_classifier #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_CLASSES = 10
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [NUM_CLASSES-1:0]              score_ready,
    input  logic signed [DATA_WIDTH-1:0]        scores [NUM_CLASSES],
    output logic [$clog2(NUM_CLASSES)-1:0]      class_index,
    output logic signed [DATA_WIDTH-1:0]        max_score,
    output logic                                result_valid,
    output logic                                busy,
    output logic                                overrun
);

    // $clog2(NUM_CLASSES) bits already reach NUM_CLASSES-1, so the scan
    // counter shares the index width without wrapping.
    localparam int IDX_W = $clog2(NUM_CLASSES);

    typedef enum logic [1:0] {
        ST_COLLECT,
        ST_SCAN,
        ST_DONE
    } state_t;

    state_t                       state_reg, state_next;
    logic [NUM_CLASSES-1:0]       flag_reg;
    logic signed [DATA_WIDTH-1:0] score_reg [NUM_CLASSES];
    logic [IDX_W-1:0]             cnt_reg;
    logic signed [DATA_WIDTH-1:0] best_score_reg;
    logic [IDX_W-1:0]             best_idx_reg;

    logic                         collecting;
    logic [NUM_CLASSES-1:0]       capture;
    logic                         all_captured;
    logic                         take;
    logic                         last;
    logic signed [DATA_WIDTH-1:0] cand_score;
    logic [IDX_W-1:0]             cand_idx;

    logic [IDX_W-1:0]             class_index_next;
    logic signed [DATA_WIDTH-1:0] max_score_next;
    logic                         result_valid_next;
    logic                         busy_next;
    logic                         overrun_next;

    assign collecting   = (state_reg == ST_COLLECT);
    assign capture      = collecting ? score_ready : '0;
    // Counts this edge's strobes too, so the scan starts on the capture edge.
    assign all_captured = &(flag_reg | score_ready);

    // Strictly-greater signed compare: ties keep the lower index.
    assign take       = (score_reg[cnt_reg] > best_score_reg);
    assign cand_score = take ? score_reg[cnt_reg] : best_score_reg;
    assign cand_idx   = take ? cnt_reg : best_idx_reg;
    assign last       = (cnt_reg == IDX_W'(NUM_CLASSES - 1));

    // ---------------------------------------------------------------- state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= ST_COLLECT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_COLLECT: if (all_captured) state_next = ST_SCAN;
            ST_SCAN:    if (last)         state_next = ST_DONE;
            ST_DONE:                      state_next = ST_COLLECT;
            default:                      state_next = ST_COLLECT;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        result_valid_next = (state_reg == ST_SCAN) && last;
        class_index_next  = result_valid_next ? cand_idx   : class_index;
        max_score_next    = result_valid_next ? cand_score : max_score;
        busy_next         = (state_next != ST_COLLECT);
        overrun_next      = overrun | (!collecting && (|score_ready));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            class_index  <= '0;
            max_score    <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            class_index  <= class_index_next;
            max_score    <= max_score_next;
            result_valid <= result_valid_next;
            busy         <= busy_next;
            overrun      <= overrun_next;
        end
    end

    // ------------------------------------------------------- score capture
    generate
        for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_score
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    score_reg[gi] <= '0;
                end else if (capture[gi]) begin
                    score_reg[gi] <= scores[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            flag_reg <= '0;
        end else if (state_reg == ST_DONE) begin
            flag_reg <= '0;
        end else begin
            flag_reg <= flag_reg | capture;
        end
    end

    // ------------------------------------------------------------ scan path
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_reg        <= '0;
            best_score_reg <= '0;
            best_idx_reg   <= '0;
        end else begin
            case (state_reg)
                ST_COLLECT: begin
                    if (all_captured) begin
                        // Score 0 may arrive on this very edge.
                        best_score_reg <= score_ready[0] ? scores[0] : score_reg[0];
                        best_idx_reg   <= '0;
                        cnt_reg        <= IDX_W'(1);
                    end
                end
                ST_SCAN: begin
                    best_score_reg <= cand_score;
                    best_idx_reg   <= cand_idx;
                    cnt_reg        <= cnt_reg + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
